// File: rtl/cpu_pkg.sv
// cpu_pkg
//   Shared definitions for the register scan reader: default widths and the
//   scan FSM state encoding.
package cpu_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int IDX_W_DEF  = 5;

  // state    | meaning
  // IDLE     | waiting for start; regNo holds the last index read
  // CAPTURE  | regNo presented to the register file, value captured on exit
  // SEND     | captured word offered on the output handshake
  // DONE     | one-cycle completion pulse, then back to IDLE
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_SEND    = 2'd2,
    ST_DONE    = 2'd3
  } scan_state_e;

endpackage

// File: rtl/reg_scan_reader.sv
// reg_scan_reader
//   Walks a contiguous (wrapping) range of register-file indices, reads each
//   value through a combinational debug read port and streams the words out
//   over a valid/ready handshake.
//
// Ports
//   clk, reset        clock, asynchronous active-high reset
//   start             scan request, honoured only when idle
//   first_reg         first index of the scan (sampled with start)
//   last_reg          last index of the scan (sampled with start)
//   regNo / val       register-file debug read port (index out, data in)
//   out_valid         out_data/out_index/out_last valid
//   out_ready         consumer accepts the current word
//   out_data          captured register value
//   out_index         index the value came from
//   out_last          final word of the scan
//   busy              high whenever a scan is in progress
//   done              one-cycle pulse after the final word is accepted
module reg_scan_reader
  import cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int IDX_W  = IDX_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [IDX_W-1:0]  first_reg,
  input  logic [IDX_W-1:0]  last_reg,
  output logic [IDX_W-1:0]  regNo,
  input  logic [DATA_W-1:0] val,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_index,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  scan_state_e       r_state;
  logic [IDX_W-1:0]  r_cur_idx;
  logic [IDX_W:0]    r_remaining;
  logic [DATA_W-1:0] r_out_data;
  logic [IDX_W-1:0]  r_out_index;
  logic              r_out_last;
  logic              r_out_valid;
  logic              r_busy;
  logic              r_done;

  logic [IDX_W-1:0]  w_span;
  logic [IDX_W:0]    w_count_init;

  // Span is taken modulo the index space so first > last wraps, and
  // first == last + 1 covers all 2**IDX_W entries (needs the extra count bit).
  assign w_span       = last_reg - first_reg;
  assign w_count_init = {1'b0, w_span} + (IDX_W + 1)'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cur_idx   <= '0;
      r_remaining <= '0;
      r_out_data  <= '0;
      r_out_index <= '0;
      r_out_last  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_cur_idx   <= first_reg;
            r_remaining <= w_count_init;
            r_busy      <= 1'b1;
            r_state     <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          r_out_data  <= val;
          r_out_index <= r_cur_idx;
          r_out_last  <= (r_remaining == (IDX_W + 1)'(1));
          r_out_valid <= 1'b1;
          r_state     <= ST_SEND;
        end
        ST_SEND: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            if (r_out_last) begin
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_cur_idx   <= r_cur_idx + IDX_W'(1);
              r_remaining <= r_remaining - (IDX_W + 1)'(1);
              r_state     <= ST_CAPTURE;
            end
          end
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy      <= 1'b0;
          r_out_valid <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign regNo     = r_cur_idx;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_index = r_out_index;
  assign out_last  = r_out_last;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_reg_scan_reader.sv
// tb_reg_scan_reader
//   Scoreboard bench: scan tasks push the expected words, a negedge monitor
//   pops and compares every accepted word and checks the done pulse.
module tb_reg_scan_reader;

  localparam int DW = 32;
  localparam int IW = 5;

  typedef struct packed {
    logic [IW-1:0] idx;
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [IW-1:0] first_reg;
  logic [IW-1:0] last_reg;
  logic [IW-1:0] regNo;
  logic [DW-1:0] val;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [IW-1:0] out_index;
  logic          out_last;
  logic          busy;
  logic          done;

  logic [DW-1:0] regs [32];
  exp_t          q[$];
  int            vectors = 0;
  int            miscompares = 0;
  int            n_done = 0;
  logic          exp_done = 1'b0;

  reg_scan_reader #(.DATA_W(DW), .IDX_W(IW)) dut (
    .clk(clk), .reset(reset), .start(start),
    .first_reg(first_reg), .last_reg(last_reg),
    .regNo(regNo), .val(val),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_index(out_index), .out_last(out_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  assign val = regs[regNo];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (reset) begin
      exp_done = 1'b0;
    end else begin
      if (exp_done || done) begin
        check("done_pulse", {31'd0, done}, {31'd0, exp_done});
        if (done) n_done++;
      end
      exp_done = 1'b0;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("unexpected_word_idx", {27'd0, out_index}, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("word_index", {27'd0, out_index}, {27'd0, e.idx});
          check("word_data", out_data, e.data);
          check("word_last", {31'd0, out_last}, {31'd0, e.last});
          if (e.last) exp_done = 1'b1;
        end
      end
    end
  end

  task automatic push_scan(input logic [IW-1:0] f, input int n);
    logic [IW-1:0] idx;
    idx = f;
    for (int i = 0; i < n; i++) begin
      q.push_back('{idx: idx, data: regs[idx], last: (i == n - 1)});
      idx = idx + 5'd1;
    end
  endtask

  task automatic issue_start(input logic [IW-1:0] f, input logic [IW-1:0] l);
    @(posedge clk); #1;
    first_reg = f;
    last_reg  = l;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_complete(input string name, input int prev_done, input int budget);
    int cyc;
    cyc = 0;
    while ((n_done == prev_done || q.size() != 0) && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    #1;
    if (cyc >= budget) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic run_scan(input string name, input logic [IW-1:0] f, input logic [IW-1:0] l, input int n);
    int prev;
    prev = n_done;
    push_scan(f, n);
    out_ready = 1'b1;
    issue_start(f, l);
    wait_complete(name, prev, 200);
    check({name, "_done_count"}, n_done - prev, 1);
    check({name, "_busy_after"}, {31'd0, busy}, 32'd0);
  endtask

  // Advance to the point where the second word is being offered, with
  // out_ready low, so it can be stalled or interrupted.
  task automatic hold_second_word(input string name);
    int cyc;
    cyc = 0;
    while (!out_valid && cyc < 20) begin @(posedge clk); #1; cyc++; end
    if (cyc >= 20) check({name, "_w1_timeout"}, 32'd0, 32'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 20) begin @(posedge clk); #1; cyc++; end
    if (cyc >= 20) check({name, "_w2_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    logic [DW-1:0] held_data;
    logic [IW-1:0] held_idx;
    int prev;

    for (int i = 0; i < 32; i++) regs[i] = DW'(i);
    regs[3] = 32'hA;
    regs[4] = 32'hB;
    regs[5] = 32'hC;

    reset = 1'b1; start = 1'b0; first_reg = '0; last_reg = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_regNo", {27'd0, regNo}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Three-word scan with latency check
    prev = n_done;
    push_scan(5'd3, 3);
    out_ready = 1'b1;
    @(posedge clk); #1;
    first_reg = 5'd3; last_reg = 5'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("lat_capture_valid", {31'd0, out_valid}, 32'd0);
    check("lat_capture_busy", {31'd0, busy}, 32'd1);
    check("lat_capture_regNo", {27'd0, regNo}, 32'd3);
    @(posedge clk); #1;
    check("lat_send_valid", {31'd0, out_valid}, 32'd1);
    wait_complete("scan3_5", prev, 100);
    check("scan3_5_done_count", n_done - prev, 1);
    check("idle_regNo_hold", {27'd0, regNo}, 32'd5);

    // Wrapping scan 30..1
    run_scan("wrap30_1", 5'd30, 5'd1, 4);
    // Single word
    run_scan("single7", 5'd7, 5'd7, 1);
    // Full index space, both ways of expressing it
    run_scan("full0_31", 5'd0, 5'd31, 32);
    run_scan("full10_9", 5'd10, 5'd9, 32);

    // Back-pressure on the second word
    prev = n_done;
    push_scan(5'd3, 3);
    out_ready = 1'b0;
    issue_start(5'd3, 5'd5);
    hold_second_word("stall");
    held_data = out_data;
    held_idx  = out_index;
    check("stall_idx_is_4", {27'd0, held_idx}, 32'd4);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_data_hold", out_data, held_data);
      check("stall_idx_hold", {27'd0, out_index}, {27'd0, held_idx});
      check("stall_valid_hold", {31'd0, out_valid}, 32'd1);
      check("stall_regNo_hold", {27'd0, regNo}, 32'd4);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_complete("stall", prev, 100);
    check("stall_done_count", n_done - prev, 1);

    // Reset during SEND of the second word
    prev = n_done;
    push_scan(5'd3, 3);
    out_ready = 1'b0;
    issue_start(5'd3, 5'd5);
    hold_second_word("rstmid");
    #1;
    reset = 1'b1;
    #1;
    check("rstmid_valid", {31'd0, out_valid}, 32'd0);
    check("rstmid_busy", {31'd0, busy}, 32'd0);
    check("rstmid_done", {31'd0, done}, 32'd0);
    check("rstmid_regNo", {27'd0, regNo}, 32'd0);
    check("rstmid_data", out_data, 32'd0);
    check("rstmid_index", {27'd0, out_index}, 32'd0);
    check("rstmid_last", {31'd0, out_last}, 32'd0);
    q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rstmid_no_done", n_done - prev, 0);
    run_scan("after_rst", 5'd20, 5'd22, 3);

    // Start while busy is ignored
    prev = n_done;
    push_scan(5'd3, 3);
    out_ready = 1'b1;
    issue_start(5'd3, 5'd5);
    @(posedge clk); #1;
    first_reg = 5'd20; last_reg = 5'd25; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_complete("ignore_start", prev, 100);
    check("ignore_start_done_count", n_done - prev, 1);
    repeat (6) @(negedge clk);
    check("ignore_start_idle", {31'd0, busy}, 32'd0);
    check("ignore_start_no_valid", {31'd0, out_valid}, 32'd0);

    check("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reg_scan_reader.md
REG_SCAN_READER -- requirements
Module: reg_scan_reader

Interface
REQ-001 SHALL have parameter: DATA_W, 32, width of register value and out_data.
REQ-002 SHALL have parameter: IDX_W, 5, register index width; the index space is 2**IDX_W entries.
REQ-003 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port: start  input  1  scan request, sampled only in IDLE.
REQ-006 SHALL have port: first_reg  input  IDX_W  first index of the scan, sampled with start.
REQ-007 SHALL have port: last_reg  input  IDX_W  last index of the scan, sampled with start.
REQ-008 SHALL have port: regNo  output  IDX_W  index driven to the register-file debug read port.
REQ-009 SHALL have port: val  input  DATA_W  combinational register-file read data for regNo.
REQ-010 SHALL have port: out_valid  output  1  out_data/out_index/out_last are valid.
REQ-011 SHALL have port: out_ready  input  1  consumer accepts the word.
REQ-012 SHALL have port: out_data  output  DATA_W  captured register value.
REQ-013 SHALL have port: out_index  output  IDX_W  index the value was read from.
REQ-014 SHALL have port: out_last  output  1  current word is the final word of the scan.
REQ-015 SHALL have port: busy  output  1  high in every state except IDLE.
REQ-016 SHALL have port: done  output  1  one-cycle pulse after the final word is accepted.

Function
REQ-017 SHALL implement FSM states IDLE, CAPTURE, SEND, DONE, encoded in a register.
REQ-018 In IDLE with start=1, SHALL latch cur_idx<=first_reg and remaining<=((last_reg-first_reg) mod 2**IDX_W)+1 in an IDX_W+1-bit count, then enter CAPTURE.
REQ-019 regNo SHALL equal cur_idx in all states; in IDLE, cur_idx holds its last value.
REQ-020 In CAPTURE, on the next edge SHALL register out_data<=val, out_index<=cur_idx, and out_last<=(remaining==1), then enter SEND; CAPTURE lasts exactly one cycle.
REQ-021 In SEND, out_valid SHALL be 1; out_data/out_index/out_last SHALL remain stable until an edge with out_ready=1.
REQ-022 On an edge in SEND with out_ready=1 and out_last=0, SHALL set cur_idx<=cur_idx+1 (wrapping 2**IDX_W-1 -> 0) and remaining<=remaining-1, then enter CAPTURE.
REQ-023 On an edge in SEND with out_ready=1 and out_last=1, SHALL enter DONE.
REQ-024 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-025 Latency: start accepted at edge N -> out_valid=1 after edge N+1; with out_ready held high, one word per 2 cycles.
REQ-026 first_reg==last_reg SHALL yield exactly one word; first_reg>last_reg SHALL wrap through index 2**IDX_W-1 to 0; first_reg=last_reg+1 mod 2**IDX_W SHALL yield all 2**IDX_W words.
REQ-027 start while busy=1 SHALL be ignored, with no queuing.
REQ-028 out_valid SHALL be 0 in IDLE, CAPTURE and DONE.
REQ-029 The value is read live in CAPTURE; a register-file write to the same index in that cycle SHALL leave the pre-edge value visible.

Reset
REQ-030 reset=1 SHALL immediately force IDLE, cur_idx=0, remaining=0, out_data=0, out_index=0, out_last=0, out_valid=0, busy=0, done=0, regNo=0.
REQ-031 Reset mid-scan SHALL abort with no done pulse; the first start after reset release SHALL begin a fresh scan.

Structure
REQ-032 The state encoding (IDLE/CAPTURE/SEND/DONE) and the IDX_W/DATA_W defaults SHALL live in shared package cpu_pkg.
REQ-033 SHALL be a single module with no sub-modules; the wrapping index counter is inline.

Verification
REQ-034 Preload regs 3..5 = 0xA,0xB,0xC; first=3, last=5, ready=1 -> words (3,0xA),(4,0xB),(5,0xC), out_last only on index 5, done 1 cycle after the third acceptance.
REQ-035 first=30, last=1, regs 30,31,0,1 = 0x1E,0x1F,0x0,0x1 -> indices 30,31,0,1 in order with those values, with 0x0 for index 0.
REQ-036 first=7, last=7 -> exactly one word, out_last=1, done pulse; first=0, last=31 -> 32 words.
REQ-037 out_ready low for 5 cycles during the second word -> out_data/out_index held constant, no index advance, no word dropped or duplicated.
REQ-038 Assert reset during SEND of the second word -> all outputs 0 in the same cycle, no done pulse; start after release rescans from the new first_reg.
REQ-039 Pulse start again during busy with different bounds -> ignored; the original scan completes unchanged.
